// File: rtl/cpu_pkg.sv
// Shared types and constants for the 9-bit RISC CPU front end.
package cpu_pkg;
  localparam int PC_W   = 9;
  localparam int INST_W = 9;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam inst_t HALT_INST = 9'b111_111_111;
  localparam pc_t   PC_MAX    = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fetch_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fetch_ir_reg.sv
// Single instruction-register slot: load, consume and flush with a valid bit.
module fetch_ir_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic [INST_W-1:0] din,
  input  logic [PC_W-1:0]   din_pc,
  output logic [INST_W-1:0] ir,
  output logic [PC_W-1:0]   ir_pc,
  output logic              valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= '0;
      ir_pc <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      ir    <= din;
      ir_pc <= din_pc;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, branch redirect and completion handshake.
// Optional FETCH_PERF_CNT_EN adds cycle_count / inst_count outputs.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [PC_W-1:0]   pc_o,
  input  logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] ir_o,
  output logic [PC_W-1:0]   ir_pc_o,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       cycle_count,
  output logic [15:0]       inst_count
`endif
);
  fetch_state_t state, state_nxt;
  pc_t   pc_q, pc_nxt;
  logic  ir_load, ir_flush;
  logic  consume, redirect, slot_free, is_halt, at_top;

  assign consume   = ir_valid & ir_ready;
  assign redirect  = consume & branch_taken;
  assign slot_free = ~ir_valid | ir_ready;
  assign is_halt   = (inst_i == HALT_INST);
  assign at_top    = (pc_q == PC_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= START_ADDR;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (!redirect && slot_free && (is_halt || at_top)) state_nxt = DRAIN;
      DRAIN: if (!ir_valid) state_nxt = DONE;
             else if (redirect) state_nxt = RUN;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // The sentinel is never loaded; a top-of-memory word is loaded but the PC
  // does not wrap.
  always_comb begin
    pc_nxt   = pc_q;
    ir_load  = 1'b0;
    ir_flush = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) pc_nxt = START_ADDR;
      RUN: begin
        if (redirect) begin
          pc_nxt   = branch_target;
          ir_flush = 1'b1;
        end else if (slot_free && is_halt) begin
          ir_flush = consume;
        end else if (slot_free) begin
          ir_load = 1'b1;
          if (!at_top) pc_nxt = pc_q + pc_t'(1);
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_nxt   = branch_target;
          ir_flush = 1'b1;
        end else if (consume) begin
          ir_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  fetch_ir_reg u_ir (
    .clk    (clk),
    .reset  (reset),
    .flush  (ir_flush),
    .load   (ir_load),
    .din    (inst_i),
    .din_pc (pc_q),
    .ir     (ir_o),
    .ir_pc  (ir_pc_o),
    .valid  (ir_valid)
  );

  assign pc_o = pc_q;
  assign done = (state == DONE);

`ifdef FETCH_PERF_CNT_EN
  logic active, restart;
  assign active  = (state == RUN) || (state == DRAIN);
  assign restart = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else if (active) begin
      cycle_count <= sat_inc16(cycle_count);
      if (consume) inst_count <= sat_inc16(inst_count);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized runs
// checked against a program-order model (expected next PC per consumed word).
module tb_fetch_unit;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  reset, start, done, ir_valid, ir_ready, branch_taken;
  pc_t   pc_o, ir_pc_o, branch_target;
  inst_t inst_i, ir_o;
  inst_t rom [512];

  int checks = 0;
  int errors = 0;
  int exp_pc;
  int issued;

  always #5 clk = ~clk;
  assign inst_i = rom[pc_o];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .done          (done),
    .pc_o          (pc_o),
    .inst_i        (inst_i),
    .ir_o          (ir_o),
    .ir_pc_o       (ir_pc_o),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle; any handshake is checked against program order first.
  task automatic step(input logic rdy, input logic br, input int tgt, input logic st);
    logic [8:0] idx;
    ir_ready = rdy; branch_taken = br; branch_target = pc_t'(tgt); start = st;
    if (ir_valid === 1'b1 && rdy) begin
      idx = exp_pc[8:0];
      chk("issue_in_program", (exp_pc < 512 && rom[idx] != HALT_INST), 1);
      chk("issue_pc", ir_pc_o, idx);
      chk("issue_word", ir_o, rom[idx]);
      exp_pc = br ? tgt : exp_pc + 1;
      issued++;
    end
    @(posedge clk); #1;
    start = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic fill_rom(input int halt_at);
    for (int i = 0; i < 512; i++) rom[i] = inst_t'($urandom_range(0, 510));
    if (halt_at >= 0) rom[halt_at] = HALT_INST;
  endtask

  task automatic begin_prog();
    exp_pc = 0; issued = 0;
    step(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic run_to_pc(input int target, input int budget);
    int n = 0;
    while (!(ir_valid === 1'b1 && ir_pc_o == pc_t'(target)) && n < budget) begin
      step(1'b1, 1'b0, 0, 1'b0); n++;
    end
    chk("reach_pc", ir_pc_o, target);
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step(1'b1, 1'b0, 0, 1'b0); n++;
    end
    chk("done", done, 1);
  endtask

  initial begin
    int k, nbr;
    logic rdy, br;
    reset = 1'b1; start = 1'b0; ir_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    exp_pc = 0; issued = 0;
    fill_rom(5);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_ir_pc", ir_pc_o, 0);
    reset = 1'b0;
    step(1'b1, 1'b1, 5, 1'b0);
    step(1'b1, 1'b1, 5, 1'b0);
    chk("idle_pc", pc_o, 0);
    chk("idle_valid", ir_valid, 0);

    // straight-line program, sentinel at 5
    begin_prog();
    k = 1;
    chk("start_pc", pc_o, 0);
    chk("start_valid", ir_valid, 0);
    step(1'b1, 1'b0, 0, 1'b0); k++;
    chk("first_valid", ir_valid, 1);
    chk("first_pc", ir_pc_o, 0);
    while (done !== 1'b1 && k < 40) begin step(1'b1, 1'b0, 0, 1'b0); k++; end
    chk("straight_done_cycle", k, 8);
    chk("straight_issued", issued, 5);
    chk("done_valid", ir_valid, 0);
    step(1'b1, 1'b1, 3, 1'b0);
    chk("done_held", done, 1);

    // stall at PC 2, then branch at PC 10 to 59
    fill_rom(20); rom[62] = HALT_INST;
    begin_prog();
    chk("restart_done_low", done, 0);
    run_to_pc(2, 10);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      chk("stall_ir_pc", ir_pc_o, 2);
      chk("stall_ir", ir_o, rom[2]);
      chk("stall_pc", pc_o, 3);
      chk("stall_valid", ir_valid, 1);
    end
    run_to_pc(10, 20);
    step(1'b1, 1'b1, 59, 1'b0);
    chk("br_bubble", ir_valid, 0);
    chk("br_pc", pc_o, 59);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("br_tgt_valid", ir_valid, 1);
    chk("br_tgt_pc", ir_pc_o, 59);
    run_to_done(30);
    chk("br_issued", issued, 14);
    chk("br_end_pc", exp_pc, 62);

    // final branch before the sentinel loops back
    fill_rom(37); rom[42] = HALT_INST;
    begin_prog();
    run_to_pc(36, 60);
    step(1'b1, 1'b1, 39, 1'b0);
    chk("loop_done_low", done, 0);
    run_to_done(30);
    chk("loop_issued", issued, 40);
    chk("loop_end_pc", exp_pc, 42);

    // top of memory: no wrap, branch out of DRAIN, then finish
    fill_rom(-1);
    begin_prog();
    run_to_pc(511, 600);
    chk("top_pc", pc_o, 511);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("top_hold_pc", pc_o, 511);
    chk("top_hold_valid", ir_valid, 1);
    chk("top_hold_done", done, 0);
    step(1'b1, 1'b1, 500, 1'b0);
    chk("drain_br_valid", ir_valid, 0);
    chk("drain_br_pc", pc_o, 500);
    chk("drain_br_done", done, 0);
    run_to_pc(511, 20);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("top_last_valid", ir_valid, 0);
    chk("top_last_done", done, 0);
    chk("top_nowrap", pc_o, 511);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("top_done", done, 1);
    chk("top_end_pc", exp_pc, 512);

    // reset mid-run
    begin_prog();
    run_to_pc(100, 120);
    reset = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0);
    reset = 1'b0;
    chk("mid_rst_valid", ir_valid, 0);
    chk("mid_rst_pc", pc_o, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ir", ir_o, 0);
    step(1'b1, 1'b1, 7, 1'b0);
    chk("mid_rst_idle_valid", ir_valid, 0);
    chk("mid_rst_idle_pc", pc_o, 0);
    begin_prog();
    step(1'b1, 1'b0, 0, 1'b0);
    chk("mid_rst_restart_pc", ir_pc_o, 0);
    chk("mid_rst_restart_valid", ir_valid, 1);
    repeat (5) step(1'b1, 1'b0, 0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0);
    reset = 1'b0;

    // randomized programs with stalls, branches and stray starts
    for (int r = 0; r < 4; r++) begin
      fill_rom(-1);
      for (int i = 0; i < 512; i++) if ($urandom_range(0, 63) == 0) rom[i] = HALT_INST;
      begin_prog();
      nbr = 0; k = 0;
      while (done !== 1'b1 && k < 8000) begin
        rdy = ($urandom_range(0, 9) < 7);
        br  = (nbr < 6) && ($urandom_range(0, 7) == 0);
        if (br && rdy && ir_valid === 1'b1) nbr++;
        step(rdy, br, int'($urandom_range(0, 511)), ($urandom_range(0, 19) == 0));
        k++;
      end
      chk("rand_done", done, 1);
      chk("rand_end", (exp_pc == 512 || rom[exp_pc[8:0]] == HALT_INST), 1);
      chk("rand_valid", ir_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
